// File: rtl/primefact_pkg.sv
// Shared types and constants for the prime factoriser and its divider.
package primefact_pkg;

    // Top-level controller states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ERROR     = 3'd1,
        ST_PG_RESET  = 3'd2,
        ST_PG_GO     = 3'd3,
        ST_PG_WAIT   = 3'd4,
        ST_DIV_START = 3'd5,
        ST_DIV_WAIT  = 3'd6,
        ST_EMIT      = 3'd7
    } state_t;

    // Default data width is 1 << DEF_WIDTH_LOG bits.
    localparam int unsigned DEF_WIDTH_LOG = 4;

    // Data width for a given log2 width.
    function automatic int unsigned width_of(input int unsigned wlog);
        return 32'd1 << wlog;
    endfunction

endpackage

// File: rtl/primefact_divqr.sv
// Restoring sequential divider: one quotient bit per cycle, WIDTH cycles per
// divide. A zero denominator still runs the full sequence but flags error.
module divqr
    import primefact_pkg::*;
#(
    parameter int unsigned WIDTH_LOG = DEF_WIDTH_LOG,
    localparam int unsigned WIDTH = 1 << WIDTH_LOG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);
    localparam int unsigned CNT_W = WIDTH_LOG + 1;

    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   r_diff;

    // One restoring step per busy cycle; quotient bits shift in from the
    // bottom while the dividend shifts out of the top into the remainder.
    always_comb begin
        busy_d  = busy_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        den_d   = den_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        r_shift = {rem_q, quot_q[WIDTH-1]};
        r_diff  = r_shift - {1'b0, den_q};
        if (busy_q) begin
            if (r_shift >= {1'b0, den_q}) begin
                rem_d  = r_diff[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = r_shift[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
        end else if (go) begin
            busy_d = 1'b1;
            cnt_d  = CNT_W'(WIDTH);
            quot_d = num;
            rem_d  = '0;
            den_d  = den;
            err_d  = (den == '0);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            den_q  <= den_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
        end
    end

    assign ready = ~busy_q;
    assign error = err_q;
    assign quot  = quot_q;
    assign rem   = rem_q;

endmodule

// File: rtl/primefact.sv
// Prime factoriser: trial-divides the input by successive primes pulled from
// primogen and streams the prime factors in ascending order over valid/ack.
module primefact
    import primefact_pkg::*;
#(
    parameter int unsigned WIDTH_LOG = DEF_WIDTH_LOG,
    localparam int unsigned WIDTH = 1 << WIDTH_LOG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    output logic             ready,
    output logic             error,
    output logic             factor_valid,
    output logic [WIDTH-1:0] factor,
    output logic             factor_last,
    input  logic             factor_ack,
    output logic             pg_rst,
    output logic             pg_go,
    input  logic             pg_ready,
    input  logic             pg_error,
    input  logic [WIDTH-1:0] pg_res
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] factor_q, factor_d;
    logic             last_q, last_d;
    logic             first_q, first_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;
    logic             pg_go_q, pg_go_d;
    logic             pg_rst_q, pg_rst_d;
    logic             div_go_q, div_go_d;

    logic             div_ready;
    logic             div_error;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    divqr #(.WIDTH_LOG(WIDTH_LOG)) u_divqr (
        .clk   (clk),
        .rst   (rst),
        .go    (div_go_q),
        .num   (n_q),
        .den   (p_q),
        .ready (div_ready),
        .error (div_error),
        .quot  (div_quot),
        .rem   (div_rem)
    );

    // Next-state logic. first_q marks the first cycle after a go pulse, when
    // the handshake partner's ready still reflects the previous request.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        p_d      = p_q;
        factor_d = factor_q;
        last_d   = last_q;
        first_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d = num;
                    if (num == '0)
                        state_d = ST_ERROR;
                    else if (num != WIDTH'(1))
                        state_d = ST_PG_RESET;
                end
            end
            ST_ERROR: ;
            ST_PG_RESET: state_d = ST_PG_GO;
            ST_PG_GO: begin
                state_d = ST_PG_WAIT;
                first_d = 1'b1;
            end
            ST_PG_WAIT: begin
                if (!first_q) begin
                    if (pg_error) begin
                        state_d = ST_ERROR;
                    end else if (pg_ready) begin
                        p_d     = pg_res;
                        state_d = ST_DIV_START;
                    end
                end
            end
            ST_DIV_START: begin
                state_d = ST_DIV_WAIT;
                first_d = 1'b1;
            end
            ST_DIV_WAIT: begin
                if (!first_q && div_ready) begin
                    if (div_error) begin
                        state_d = ST_ERROR;
                    end else if (div_rem == '0) begin
                        // p divides n: emit p, keep dividing by the same p.
                        factor_d = p_q;
                        last_d   = (div_quot == WIDTH'(1));
                        n_d      = div_quot;
                        state_d  = ST_EMIT;
                    end else if (div_quot < p_q) begin
                        // p*p > n, so what remains of n is itself prime.
                        factor_d = n_q;
                        last_d   = 1'b1;
                        state_d  = ST_EMIT;
                    end else begin
                        state_d = ST_PG_GO;
                    end
                end
            end
            ST_EMIT: begin
                if (factor_ack) state_d = last_q ? ST_IDLE : ST_DIV_START;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered copies of decodes of the next state.
    always_comb begin
        ready_d  = (state_d == ST_IDLE) || (state_d == ST_ERROR);
        error_d  = (state_d == ST_ERROR);
        valid_d  = (state_d == ST_EMIT);
        pg_go_d  = (state_d == ST_PG_GO);
        pg_rst_d = (state_d == ST_PG_RESET);
        div_go_d = (state_d == ST_DIV_START);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            p_q      <= '0;
            factor_q <= '0;
            last_q   <= 1'b0;
            first_q  <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            error_q  <= 1'b0;
            pg_go_q  <= 1'b0;
            pg_rst_q <= 1'b1;
            div_go_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            p_q      <= p_d;
            factor_q <= factor_d;
            last_q   <= last_d;
            first_q  <= first_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
            pg_go_q  <= pg_go_d;
            pg_rst_q <= pg_rst_d;
            div_go_q <= div_go_d;
        end
    end

    assign ready        = ready_q;
    assign error        = error_q;
    assign factor_valid = valid_q;
    assign factor       = factor_q;
    assign factor_last  = last_q;
    assign pg_go        = pg_go_q;
    assign pg_rst       = pg_rst_q;

endmodule

// File: tb/tb_primefact.sv
// Bench for primefact: behavioural primogen, table of known factorisations,
// random numbers against a trial-division model, and corner-case sequences.
module tb_primefact;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num = '0;
    logic        ready, error, factor_valid, factor_last;
    logic [15:0] factor;
    logic        factor_ack = 1'b0;
    logic        pg_rst, pg_go;
    logic        pg_ready = 1'b0;
    logic        pg_error = 1'b0;
    logic [15:0] pg_res = '0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] got_f[$];
    logic        got_l[$];

    primefact #(.WIDTH_LOG(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num          (num),
        .ready        (ready),
        .error        (error),
        .factor_valid (factor_valid),
        .factor       (factor),
        .factor_last  (factor_last),
        .factor_ack   (factor_ack),
        .pg_rst       (pg_rst),
        .pg_go        (pg_go),
        .pg_ready     (pg_ready),
        .pg_error     (pg_error),
        .pg_res       (pg_res)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- primogen behavioural model ----------------
    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int d = 2; d * d <= v; d++)
            if (v % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int next_prime(input int v);
        int k = v + 1;
        while (!is_prime(k)) k++;
        return k;
    endfunction

    bit inject_err = 1'b0;
    int lag = 0;
    int pg_cnt = 0;

    // Ready stays stale for one cycle after go, then drops, then returns
    // with the next prime after a random delay.
    always @(posedge clk) begin
        int nxt;
        if (pg_rst) begin
            pg_res   <= 16'd1;
            pg_ready <= 1'b1;
            pg_error <= 1'b0;
            lag      <= 0;
            pg_cnt   <= 0;
        end else if (pg_go) begin
            lag <= 1;
        end else if (lag == 1) begin
            lag      <= 0;
            pg_ready <= 1'b0;
            pg_cnt   <= $urandom_range(0, 3);
        end else if (!pg_ready && !pg_error) begin
            if (pg_cnt > 0) begin
                pg_cnt <= pg_cnt - 1;
            end else if (inject_err) begin
                pg_error <= 1'b1;
            end else begin
                nxt = next_prime(int'(pg_res));
                if (nxt > 65535) pg_error <= 1'b1;
                else begin
                    pg_res   <= 16'(nxt);
                    pg_ready <= 1'b1;
                end
            end
        end
    end

    // ---------------- reference factorisation ----------------
    function automatic void factorize(input int v, output int fs[$]);
        int n = v;
        fs.delete();
        for (int d = 2; d * d <= n; d++)
            while (n % d == 0) begin
                fs.push_back(d);
                n = n / d;
            end
        if (n > 1) fs.push_back(n);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        factor_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Start one number and collect its factors. am: 0 random ack, 1 ack tied
    // high, 2 hold ack low 5 cycles per factor. poke drives junk starts while busy.
    task automatic run_num(input logic [15:0] v, input int am, input bit poke);
        int hold = 0;
        bit pv = 0, pa = 0, done = 0;
        logic [15:0] pf = '0;
        logic pl = 1'b0;
        got_f.delete();
        got_l.delete();
        @(negedge clk);
        start = 1'b1;
        num = v;
        @(negedge clk);
        start = 1'b0;
        num = 16'($urandom);
        for (int c = 0; c < 20000 && !done; c++) begin
            if (factor_valid && pv && !pa) begin
                chk("hold_factor", 32'(factor), 32'(pf));
                chk("hold_last", 32'(factor_last), 32'(pl));
            end
            if (ready && !factor_valid) begin
                done = 1;
            end else begin
                if (factor_valid) begin
                    case (am)
                        1:       factor_ack = 1'b1;
                        2:       factor_ack = (hold >= 5);
                        default: factor_ack = ($urandom_range(0, 2) != 0);
                    endcase
                end else begin
                    factor_ack = 1'($urandom_range(0, 1));
                end
                if (factor_valid && factor_ack) begin
                    got_f.push_back(factor);
                    got_l.push_back(factor_last);
                    hold = 0;
                end else if (factor_valid) begin
                    hold++;
                end
                pv = factor_valid;
                pa = factor_ack;
                pf = factor;
                pl = factor_last;
                if (poke) begin
                    start = 1'($urandom_range(0, 1));
                    num = 16'($urandom);
                end
                @(negedge clk);
            end
        end
        factor_ack = 1'b0;
        start = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: num=%0d never returned to ready", v);
        end
    endtask

    // Compare collected factors against an expected list.
    task automatic chk_list(input string tag, input int exp[$]);
        chk($sformatf("%s count", tag), 32'(got_f.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got_f.size(); i++) begin
            chk($sformatf("%s factor[%0d]", tag, i), 32'(got_f[i]), 32'(exp[i]));
            chk($sformatf("%s last[%0d]", tag, i), 32'(got_l[i]), 32'(i == exp.size() - 1));
        end
    endtask

    typedef struct {
        logic [15:0] num;
        int          am;
        int          nf;
        int          f0, f1, f2, f3, f4, f5;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int exp[$];
        int c;
        int seen;

        vecs[0] = '{16'd360,   1, 6, 2, 2, 2, 3, 3, 5};
        vecs[1] = '{16'd65535, 0, 4, 3, 5, 17, 257, 0, 0};
        vecs[2] = '{16'd65521, 0, 1, 65521, 0, 0, 0, 0, 0};
        vecs[3] = '{16'd1,     1, 0, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{16'd12,    2, 3, 2, 2, 3, 0, 0, 0};
        vecs[5] = '{16'd2,     1, 1, 2, 0, 0, 0, 0, 0};
        vecs[6] = '{16'd65534, 0, 4, 2, 7, 31, 151, 0, 0};
        vecs[7] = '{16'd4,     0, 2, 2, 2, 0, 0, 0, 0};
        vecs[8] = '{16'd49,    1, 2, 7, 7, 0, 0, 0, 0};
        vecs[9] = '{16'd65025, 0, 6, 3, 3, 5, 5, 17, 17};

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        chk("rst ready", 32'(ready), 1);
        chk("rst error", 32'(error), 0);
        chk("rst factor_valid", 32'(factor_valid), 0);
        chk("rst factor", 32'(factor), 0);
        chk("rst factor_last", 32'(factor_last), 0);
        chk("rst pg_go", 32'(pg_go), 0);
        chk("rst pg_rst", 32'(pg_rst), 1);
        rst = 1'b0;

        // Table of known factorisations.
        for (int i = 0; i < 10; i++) begin
            int all[6];
            all = '{vecs[i].f0, vecs[i].f1, vecs[i].f2, vecs[i].f3, vecs[i].f4, vecs[i].f5};
            exp.delete();
            for (int k = 0; k < vecs[i].nf; k++) exp.push_back(all[k]);
            run_num(vecs[i].num, vecs[i].am, 1'b0);
            chk_list($sformatf("vec%0d(%0d)", i, vecs[i].num), exp);
            chk($sformatf("vec%0d ready", i), 32'(ready), 1);
            chk($sformatf("vec%0d error", i), 32'(error), 0);
        end

        // Random numbers against the trial-division model, with junk starts
        // and acks thrown at the DUT while it is busy.
        for (int i = 0; i < 15; i++) begin
            int v;
            v = $urandom_range(2, 65535);
            factorize(v, exp);
            run_num(16'(v), 0, 1'b1);
            chk_list($sformatf("rand%0d(%0d)", i, v), exp);
        end

        // num=0 goes to sticky ERROR; a later start is ignored.
        run_num(16'd0, 1, 1'b0);
        chk("zero error", 32'(error), 1);
        chk("zero ready", 32'(ready), 1);
        @(negedge clk);
        start = 1'b1;
        num = 16'd12;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (factor_valid) seen++;
        end
        chk("err start ignored valid", 32'(seen), 0);
        chk("err sticky", 32'(error), 1);
        do_reset();
        chk("err cleared", 32'(error), 0);

        // Reset during a divide of 1001, then a clean rerun.
        @(negedge clk);
        start = 1'b1;
        num = 16'd1001;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (!pg_go && c < 200) begin @(negedge clk); c++; end
        while (pg_ready && c < 200) begin @(negedge clk); c++; end
        while (!pg_ready && c < 200) begin @(negedge clk); c++; end
        chk("div_wait reach", 32'(c < 200), 1);
        repeat (4) @(negedge clk);
        chk("div_wait busy", 32'(ready), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst factor_valid", 32'(factor_valid), 0);
        chk("midrst ready", 32'(ready), 1);
        chk("midrst pg_rst", 32'(pg_rst), 1);
        rst = 1'b0;
        run_num(16'd1001, 0, 1'b0);
        exp = '{7, 11, 13};
        chk_list("after_rst(1001)", exp);

        // primogen error while waiting for a prime.
        inject_err = 1'b1;
        @(negedge clk);
        start = 1'b1;
        num = 16'd1001;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        seen = 0;
        while (!error && c < 200) begin
            @(negedge clk);
            if (factor_valid) seen++;
            c++;
        end
        chk("pgerr error", 32'(error), 1);
        chk("pgerr ready", 32'(ready), 1);
        repeat (30) begin
            @(negedge clk);
            if (factor_valid) seen++;
        end
        chk("pgerr no factor", 32'(seen), 0);
        inject_err = 1'b0;
        do_reset();
        run_num(16'd360, 1, 1'b0);
        exp = '{2, 2, 2, 3, 3, 5};
        chk_list("after_err(360)", exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
